// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM command/data port between two burst requesters.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 win every tie (requester 1 may starve).
module burst_ram_arbiter #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // requester 0
  input  logic                      m0_cmd,
  input  logic                      m0_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m0_addr,
  input  logic [63:0]               m0_wr_data,
  input  logic [7:0]                m0_data_mask,
  output logic                      m0_grant,
  output logic [63:0]               m0_rd_data,
  output logic                      m0_rd_data_valid,
  output logic                      m0_busy,
  // requester 1
  input  logic                      m1_cmd,
  input  logic                      m1_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m1_addr,
  input  logic [63:0]               m1_wr_data,
  input  logic [7:0]                m1_data_mask,
  output logic                      m1_grant,
  output logic [63:0]               m1_rd_data,
  output logic                      m1_rd_data_valid,
  output logic                      m1_busy,
  // BurstRAM side
  output logic                      br_cmd,
  output logic                      br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]               br_wr_data,
  output logic [7:0]                br_data_mask,
  input  logic [63:0]               br_rd_data,
  input  logic                      br_rd_data_valid,
  input  logic                      br_busy,
  input  logic                      br_init_calib
);

  localparam int CNT_W = (BURST_COUNT > 2) ? $clog2(BURST_COUNT) : 1;
  // Write bursts end one beat early in the counter because beat 0 rides on the issue cycle.
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(BURST_COUNT - 2);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(BURST_COUNT - 1);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t           state, state_next;
  logic             owner, owner_next;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_next;
  logic             winner;
  logic             sel;
  logic             issue;
  logic             rd_fwd;
`ifndef ARB_FIXED_PRIORITY_EN
  logic             last, last_next;
`endif

  always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
    winner = ~m0_cmd_en;
`else
    if (m0_cmd_en && m1_cmd_en) winner = ~last;
    else                        winner = ~m0_cmd_en;
`endif
  end

  // Issue is gated by rst_n so no grant can escape while reset is held.
  assign issue = (state == IDLE) && rst_n && br_init_calib && !br_busy &&
                 (m0_cmd_en || m1_cmd_en);
  assign sel   = (state == IDLE) ? winner : owner;

  assign br_cmd       = sel ? m1_cmd       : m0_cmd;
  assign br_addr      = sel ? m1_addr      : m0_addr;
  assign br_wr_data   = sel ? m1_wr_data   : m0_wr_data;
  assign br_data_mask = sel ? m1_data_mask : m0_data_mask;
  assign br_cmd_en    = issue;

  assign m0_grant = issue && !winner;
  assign m1_grant = issue &&  winner;

  assign rd_fwd           = (state == RD) && br_rd_data_valid;
  assign m0_rd_data_valid = rd_fwd && !owner;
  assign m1_rd_data_valid = rd_fwd &&  owner;
  assign m0_rd_data       = br_rd_data;
  assign m1_rd_data       = br_rd_data;

  assign m0_busy = (state != IDLE) && !owner;
  assign m1_busy = (state != IDLE) &&  owner;

  always_comb begin
    state_next    = state;
    owner_next    = owner;
    beat_cnt_next = beat_cnt;
`ifndef ARB_FIXED_PRIORITY_EN
    last_next     = last;
`endif
    case (state)
      IDLE: begin
        if (issue) begin
          owner_next    = winner;
`ifndef ARB_FIXED_PRIORITY_EN
          last_next     = winner;
`endif
          beat_cnt_next = '0;
          state_next    = br_cmd ? WR : RD;
        end
      end
      WR: begin
        beat_cnt_next = beat_cnt + 1'b1;
        if (beat_cnt == WR_LAST) state_next = IDLE;
      end
      RD: begin
        if (br_rd_data_valid) begin
          beat_cnt_next = beat_cnt + 1'b1;
          if (beat_cnt == RD_LAST) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      beat_cnt <= beat_cnt_next;
    end
  end

`ifndef ARB_FIXED_PRIORITY_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= 1'b1;
    else        last <= last_next;
  end
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small BurstRAM model (read latency 6, 4 beats).
module tb_burst_ram_arbiter;

  typedef logic [63:0] burst_t [4];

`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam logic [2:0] READ_LAT = 3'd6;

  logic        clk, rst_n;
  logic        m0_cmd, m0_cmd_en, m1_cmd, m1_cmd_en;
  logic [3:0]  m0_addr, m1_addr;
  logic [63:0] m0_wr_data, m1_wr_data;
  logic [7:0]  m0_data_mask, m1_data_mask;
  logic        m0_grant, m0_rd_data_valid, m0_busy;
  logic        m1_grant, m1_rd_data_valid, m1_busy;
  logic [63:0] m0_rd_data, m1_rd_data;
  logic        br_cmd, br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_wr_data, br_rd_data;
  logic [7:0]  br_data_mask;
  logic        br_rd_data_valid, br_busy, br_init_calib;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;

  int          g0_q[$], g1_q[$], v0_cyc[$], v1_cyc[$], b0_fall[$];
  logic [63:0] v0_dat[$], v1_dat[$];
  logic        prev_b0 = 1'b0;

  logic [63:0] wmem [16][4];
  bit          wflag [16][4];
  logic [3:0]  rd_addr, wr_addr;
  logic [2:0]  rd_delay;
  logic [1:0]  rd_beat, wr_beat;
  logic        rd_active, wr_active;

  burst_ram_arbiter #(.DEPTH_BITWIDTH(4), .BURST_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd(m0_cmd), .m0_cmd_en(m0_cmd_en), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_data_mask(m0_data_mask), .m0_grant(m0_grant),
    .m0_rd_data(m0_rd_data), .m0_rd_data_valid(m0_rd_data_valid), .m0_busy(m0_busy),
    .m1_cmd(m1_cmd), .m1_cmd_en(m1_cmd_en), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_data_mask(m1_data_mask), .m1_grant(m1_grant),
    .m1_rd_data(m1_rd_data), .m1_rd_data_valid(m1_rd_data_valid), .m1_busy(m1_busy),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
    .br_busy(br_busy), .br_init_calib(br_init_calib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input logic [3:0] a, input logic [1:0] k);
    return {32'hD00DF00D, 16'h0, 4'h0, a, 6'h0, k};
  endfunction

  function automatic burst_t patBurst(input logic [3:0] a);
    burst_t b;
    for (int k = 0; k < 4; k++) b[k] = pat(a, 2'(k));
    return b;
  endfunction

  function automatic logic [63:0] ramWord(input logic [3:0] a, input logic [1:0] k);
    return wflag[a][k] ? wmem[a][k] : pat(a, k);
  endfunction

  function automatic int countRange(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  // BurstRAM model: first read beat 6 cycles after issue, beats back to back; write beat 0 on issue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_rd_data_valid <= 1'b0;
      br_rd_data       <= '0;
      rd_addr <= '0; wr_addr <= '0; rd_delay <= '0;
      rd_beat <= '0; wr_beat <= '0; rd_active <= 1'b0; wr_active <= 1'b0;
      for (int a = 0; a < 16; a++) for (int k = 0; k < 4; k++) wflag[a][k] <= 1'b0;
    end else begin
      br_rd_data_valid <= 1'b0;
      if (br_cmd_en && !br_cmd) begin
        rd_addr  <= br_addr;
        rd_delay <= READ_LAT - 3'd1;
      end else if (rd_delay > 3'd1) begin
        rd_delay <= rd_delay - 3'd1;
      end else if (rd_delay == 3'd1) begin
        rd_delay <= '0;
        br_rd_data_valid <= 1'b1;
        br_rd_data <= ramWord(rd_addr, 2'd0);
        rd_beat <= 2'd1;
        rd_active <= 1'b1;
      end else if (rd_active) begin
        br_rd_data_valid <= 1'b1;
        br_rd_data <= ramWord(rd_addr, rd_beat);
        rd_beat <= rd_beat + 2'd1;
        if (rd_beat == 2'd3) rd_active <= 1'b0;
      end
      if (br_cmd_en && br_cmd) begin
        wmem[br_addr][0]  <= br_wr_data;
        wflag[br_addr][0] <= 1'b1;
        wr_addr <= br_addr;
        wr_beat <= 2'd1;
        wr_active <= 1'b1;
      end else if (wr_active) begin
        wmem[wr_addr][wr_beat]  <= br_wr_data;
        wflag[wr_addr][wr_beat] <= 1'b1;
        wr_beat <= wr_beat + 2'd1;
        if (wr_beat == 2'd3) wr_active <= 1'b0;
      end
    end
  end

  // Record grants, forwarded beats and the falling edge of m0_busy with their cycle numbers.
  always @(negedge clk) begin
    if (m0_grant) g0_q.push_back(cyc);
    if (m1_grant) g1_q.push_back(cyc);
    if (m0_rd_data_valid) begin v0_cyc.push_back(cyc); v0_dat.push_back(m0_rd_data); end
    if (m1_rd_data_valid) begin v1_cyc.push_back(cyc); v1_dat.push_back(m1_rd_data); end
    if (prev_b0 && !m0_busy) b0_fall.push_back(cyc);
    prev_b0 <= m0_busy;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic checkBurst(input string tag, input int port, input int base, input int first,
                            input burst_t exp);
    int n, cy;
    logic [63:0] d;
    n = (port == 0) ? v0_cyc.size() : v1_cyc.size();
    checkOutput({tag, "_count"}, 64'(n - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < n) begin
        cy = (port == 0) ? v0_cyc[base+k] : v1_cyc[base+k];
        d  = (port == 0) ? v0_dat[base+k] : v1_dat[base+k];
        checkOutput({tag, "_cyc"}, 64'(cy), 64'(first + k));
        checkOutput({tag, "_data"}, d, exp[k]);
      end
    end
  endtask

  // Advance n cycles; a requester drops cmd_en the cycle after it sees its grant.
  task automatic runCycles(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g0 = m0_grant;
      g1 = m1_grant;
      @(posedge clk); #1;
      if (g0) m0_cmd_en = 1'b0;
      if (g1) m1_cmd_en = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int port, input logic cmd, input logic [3:0] addr);
    if (port == 0) begin m0_cmd = cmd; m0_addr = addr; m0_cmd_en = 1'b1; end
    else           begin m1_cmd = cmd; m1_addr = addr; m1_cmd_en = 1'b1; end
  endtask

  task automatic applyReset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tieTest(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                         input bit first_port);
    int c, b0, b1, f0, f1;
    c = cyc; b0 = v0_cyc.size(); b1 = v1_cyc.size();
    f0 = first_port ? c + 10 : c;
    f1 = first_port ? c : c + 10;
    applyStimulus(0, 1'b0, a0);
    applyStimulus(1, 1'b0, a1);
    runCycles(24);
    checkOutput({tag, "_g0_at"}, 64'(countRange(g0_q, f0, f0)), 64'd1);
    checkOutput({tag, "_g1_at"}, 64'(countRange(g1_q, f1, f1)), 64'd1);
    checkOutput({tag, "_g0_total"}, 64'(countRange(g0_q, c, c + 23)), 64'd1);
    checkBurst({tag, "_p0"}, 0, b0, f0 + 6, patBurst(a0));
    checkBurst({tag, "_p1"}, 1, b1, f1 + 6, patBurst(a1));
  endtask

  task automatic stallTest(input string tag, input bit use_calib, input int port,
                           input logic [3:0] addr, input int n);
    int c, base, bad;
    bad = 0;
    base = (port == 0) ? v0_cyc.size() : v1_cyc.size();
    if (use_calib) br_init_calib = 1'b0;
    else           br_busy = 1'b1;
    applyStimulus(port, 1'b0, addr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m0_grant || m1_grant || br_cmd_en) bad++;
      @(posedge clk); #1;
    end
    br_init_calib = 1'b1;
    br_busy = 1'b0;
    c = cyc;
    @(negedge clk);
    checkOutput({tag, "_no_early"}, 64'(bad), 64'd0);
    checkOutput({tag, "_grant"}, 64'((port == 0) ? m0_grant : m1_grant), 64'd1);
    checkOutput({tag, "_cmd_en"}, 64'(br_cmd_en), 64'd1);
    checkOutput({tag, "_addr"}, 64'(br_addr), 64'(addr));
    @(posedge clk); #1;
    m0_cmd_en = 1'b0;
    m1_cmd_en = 1'b0;
    runCycles(12);
    checkBurst(tag, port, base, c + 6, patBurst(addr));
  endtask

  initial begin
    int c, c2, b0, b1;
    burst_t wexp;
    logic [7:0] mexp [4];
    wexp = '{64'h11, 64'h22, 64'h33, 64'h44};
    mexp = '{8'hA5, 8'h5A, 8'hF0, 8'h0F};

    rst_n = 1'b1;
    m0_cmd = 1'b0; m0_cmd_en = 1'b0; m0_addr = '0; m0_wr_data = '0; m0_data_mask = '0;
    m1_cmd = 1'b0; m1_cmd_en = 1'b0; m1_addr = '0; m1_wr_data = '0; m1_data_mask = '0;
    br_busy = 1'b0; br_init_calib = 1'b1;
    #2 rst_n = 1'b0;
    m0_cmd_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_m0_grant", 64'(m0_grant), 64'd0);
    checkOutput("rst_m1_grant", 64'(m1_grant), 64'd0);
    checkOutput("rst_br_cmd_en", 64'(br_cmd_en), 64'd0);
    checkOutput("rst_m0_busy", 64'(m0_busy), 64'd0);
    checkOutput("rst_m1_busy", 64'(m1_busy), 64'd0);
    checkOutput("rst_m0_valid", 64'(m0_rd_data_valid), 64'd0);
    checkOutput("rst_m1_valid", 64'(m1_rd_data_valid), 64'd0);
    m0_cmd_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] tie after reset");
    tieTest("tie1", 4'd3, 4'd7, 1'b0);

    $display("[TB] single read port 0");
    c = cyc; b0 = v0_cyc.size(); b1 = v1_cyc.size();
    applyStimulus(0, 1'b0, 4'd2);
    runCycles(14);
    checkOutput("single_g0_at", 64'(countRange(g0_q, c, c)), 64'd1);
    checkOutput("single_g0_total", 64'(countRange(g0_q, c, c + 13)), 64'd1);
    checkOutput("single_g1_total", 64'(countRange(g1_q, c, c + 13)), 64'd0);
    checkOutput("single_m1_valids", 64'(v1_cyc.size() - b1), 64'd0);
    checkOutput("single_busy_fall", 64'(countRange(b0_fall, c + 10, c + 10)), 64'd1);
    checkBurst("single", 0, b0, c + 6, patBurst(4'd2));

    $display("[TB] repeated tie");
    tieTest("tie2", 4'd1, 4'd9, FIXED ? 1'b0 : 1'b1);

    $display("[TB] write burst port 1");
    m1_cmd = 1'b1; m1_addr = 4'd5; m1_wr_data = wexp[0]; m1_data_mask = mexp[0]; m1_cmd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("wr_data", br_wr_data, wexp[k]);
      checkOutput("wr_mask", 64'(br_data_mask), 64'(mexp[k]));
      checkOutput("wr_cmd_en", 64'(br_cmd_en), (k == 0) ? 64'd1 : 64'd0);
      checkOutput("wr_m1_grant", 64'(m1_grant), (k == 0) ? 64'd1 : 64'd0);
      checkOutput("wr_m1_busy", 64'(m1_busy), (k == 0) ? 64'd0 : 64'd1);
      @(posedge clk); #1;
      m1_cmd_en = 1'b0;
      if (k < 3) begin m1_wr_data = wexp[k+1]; m1_data_mask = mexp[k+1]; end
    end
    @(negedge clk);
    checkOutput("wr_busy_done", 64'(m1_busy), 64'd0);
    @(posedge clk); #1;
    m1_cmd = 1'b0;
    c = cyc; b0 = v0_cyc.size();
    applyStimulus(0, 1'b0, 4'd5);
    runCycles(14);
    checkBurst("readback", 0, b0, c + 6, wexp);

    $display("[TB] stalls");
    stallTest("busy_stall", 1'b0, 0, 4'd4, 10);
    stallTest("calib_stall", 1'b1, 1, 4'd6, 3);

    $display("[TB] reset mid-read");
    c = cyc; b0 = v0_cyc.size();
    applyStimulus(0, 1'b0, 4'd8);
    runCycles(8);
    checkOutput("midrst_beats_before", 64'(v0_cyc.size() - b0), 64'd2);
    checkOutput("midrst_busy_before", 64'(m0_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(m0_busy), 64'd0);
    checkOutput("midrst_valid", 64'(m0_rd_data_valid), 64'd0);
    checkOutput("midrst_cmd_en", 64'(br_cmd_en), 64'd0);
    checkOutput("midrst_grant", 64'(m0_grant), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    c2 = cyc; b0 = v0_cyc.size(); b1 = v1_cyc.size();
    applyStimulus(1, 1'b0, 4'd10);
    runCycles(14);
    checkOutput("postrst_g1_at", 64'(countRange(g1_q, c2, c2)), 64'd1);
    checkOutput("postrst_m0_valids", 64'(v0_cyc.size() - b0), 64'd0);
    checkBurst("postrst", 1, b1, c2 + 6, patBurst(4'd10));

    $display("[TB] continuous requests");
    applyReset(2);
    c = cyc;
    applyStimulus(0, 1'b0, 4'd11);
    applyStimulus(1, 1'b0, 4'd12);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    m0_cmd_en = 1'b0;
    m1_cmd_en = 1'b0;
    runCycles(12);
    checkOutput("cont_g0_count", 64'(countRange(g0_q, c, c + 20)), FIXED ? 64'd3 : 64'd2);
    checkOutput("cont_g1_count", 64'(countRange(g1_q, c, c + 20)), FIXED ? 64'd0 : 64'd1);
    checkOutput("cont_mid_g0", 64'(countRange(g0_q, c + 10, c + 10)), FIXED ? 64'd1 : 64'd0);
    checkOutput("cont_last_g0", 64'(countRange(g0_q, c + 20, c + 20)), 64'd1);
    checkOutput("cont_m0_busy_end", 64'(m0_busy), 64'd0);
    checkOutput("cont_m1_busy_end", 64'(m1_busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/burst_ram_arbiter.md
# burst_ram_arbiter

Shares one BurstRAM command/data port between two burst requesters (e.g. instruction cache and data cache), each wired with the same `br_` signal set the Cache block drives. Requests are granted round-robin, and a grant covers exactly one whole burst, read or write. Read data is routed back only to the owning requester. The block sits between the caches and BurstRAM, on the BurstRAM clock.

## Interface

Parameters:
- `DEPTH_BITWIDTH`, 4: width of the burst address (8-byte words).
- `BURST_COUNT`, 4: 64-bit beats per burst; must be at least 2.

Ports:
- `clk` in 1: BurstRAM clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `mN_cmd` in 1 (N = 0, 1): 0 read, 1 write.
- `mN_cmd_en` in 1: request. Held high, with `mN_cmd`/`mN_addr` stable, until `mN_grant`.
- `mN_addr` in `DEPTH_BITWIDTH`: burst address.
- `mN_wr_data` in 64: write beat.
- `mN_data_mask` in 8: write mask, passed through.
- `mN_grant` out 1: one-cycle pulse; the command is issued to RAM this cycle.
- `mN_rd_data` out 64: `br_rd_data` broadcast to both requesters.
- `mN_rd_data_valid` out 1: read beat valid for this requester only.
- `mN_busy` out 1: high while this requester's burst is in flight.
- `br_cmd`, `br_cmd_en`, `br_addr`, `br_wr_data`, `br_data_mask` out: BurstRAM command side.
- `br_rd_data` in 64; `br_rd_data_valid` in 1.
- `br_busy` in 1; `br_init_calib` in 1.

## Operation

FSM states:
- IDLE: no burst owned.
- WR: owner is driving write beats 1..`BURST_COUNT`-1.
- RD: waiting for `BURST_COUNT` read beats.

Registers:
- `owner`: requester that holds the current burst.
- `last`: requester granted most recently.
- `beat_cnt`: width clog2(`BURST_COUNT`).

IDLE issue rules:
- Issue is allowed when `br_init_calib` is 1, `br_busy` is 0, and at least one `mN_cmd_en` is 1.
- Winner:
  - If exactly one requester is requesting, that one wins.
  - If both are requesting, the requester other than `last` wins.
- Issue cycle (combinational):
  - `br_cmd_en`=1 and `mW_grant`=1.
  - `br_cmd`/`br_addr`/`br_wr_data`/`br_data_mask` come from the winner W.
- Registered updates on the issue cycle: `owner`<=W, `last`<=W, `beat_cnt`<=0.
- Next state: WR if write, RD if read.

WR:
- `br_wr_data`/`br_data_mask` are muxed from `owner`; `br_cmd_en`=0.
- `beat_cnt` increments every cycle.
- Go to IDLE after the cycle carrying beat `BURST_COUNT`-1, i.e. `BURST_COUNT`-1 cycles after issue.

RD:
- `mOwner_rd_data_valid` = `br_rd_data_valid`; the other requester's valid is 0.
- `beat_cnt` increments per valid beat.
- Go to IDLE on the cycle of the last valid beat.

Other rules:
- `mN_busy` = (state != IDLE && `owner`==N).
- `br_rd_data_valid` in IDLE or WR is ignored: no valid is forwarded to either requester.
- A requester that holds `cmd_en` high through its own burst is not granted again until that burst completes and IDLE re-arbitrates.
- No burst is split or preempted.

Reset (`rst_n`=0):
- State IDLE, `owner`=0, `last`=1 so requester 0 wins the first tie, `beat_cnt`=0.
- All grants, valids and busys are 0; `br_cmd_en`=0.
- Reset mid-burst abandons the burst; BurstRAM is reset by the same system reset.

## Timing

- Grant latency: 0 cycles from a qualifying `mN_cmd_en` in IDLE.
- Write burst: the issue cycle carries beat 0, then beats 1..`BURST_COUNT`-1 on consecutive cycles.
  - The requester presents beat k exactly k cycles after its grant.
  - Earliest next issue: `BURST_COUNT` cycles after the previous issue.
- Read burst: the bus stays owned until the last beat arrives.
  - Valid forwarding adds no delay (same cycle as `br_rd_data_valid`).
  - Earliest next issue is the cycle after the last beat.
- `br_busy`=1 in IDLE blocks issue. `br_busy` is ignored in WR and RD.
- `br_init_calib`=0 blocks issue.

## Configuration

- `ARB_FIXED_PRIORITY_EN` defined:
  - Requester 0 wins every tie; `last` is unused.
  - Requester 1 can starve.
- Not defined: round-robin as above.

## Test plan

- Single read, port 0, addr 2, RAM read latency 6:
  - `m0_grant` pulses once.
  - `m0_rd_data_valid` is high for exactly 4 cycles with the RAM beats; `m1_rd_data_valid` stays 0.
  - `m0_busy` falls on the last beat.
- Both ports request reads at the same cycle after reset:
  - Port 0 is granted first.
  - Port 1 is granted the cycle after port 0's 4th beat.
  - Repeating the tie grants port 1 first.
- Write from port 1, addr 5, beats 0x11..0x44:
  - `br_wr_data` shows 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting at the grant.
  - Reading addr 5 back returns the same beats.
- `br_busy`=1 for 10 cycles with `m0_cmd_en` held:
  - No grant during the stall.
  - Grant and `br_cmd_en` occur in the first cycle `br_busy`=0.
- Reset asserted after the 2nd read beat:
  - All outputs go to 0 immediately.
  - After release, a new port 1 read completes normally with no stale valids.
- With `ARB_FIXED_PRIORITY_EN`, both ports requesting continuously: port 0 is granted 3 times in a row, port 1 never.
